// File: rtl/gcm_pkg.sv
// Shared GCM definitions: block type, GHASH sequencer states, constants and
// the bit-serial GF(2^128) product used as the reference multiplier model.
package gcm_pkg;

  localparam int BLK_W = 128;

  typedef logic [0:BLK_W-1] block_t;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WAIT,
    LEN,
    DONE
  } ghash_state_t;

  localparam block_t ZERO_BLK = '0;

  // Reduction constant 11100001 || 0^120 (bit 0 is the leftmost bit).
  localparam block_t R_POLY = 128'he1000000_00000000_00000000_00000000;

  // GF(2^128) product in GCM bit order: bit 0 of each operand is the
  // coefficient of x^0, so "shift right" moves toward higher indices.
  function automatic block_t fn_product(input block_t x, input block_t y);
    block_t z;
    block_t v;
    z = ZERO_BLK;
    v = y;
    for (int i = 0; i < BLK_W; i++) begin
      if (x[i]) z = z ^ v;
      if (v[BLK_W-1]) v = (v >> 1) ^ R_POLY;
      else            v = v >> 1;
    end
    return z;
  endfunction

endpackage

// File: rtl/ghash_sequencer.sv
// GHASH sequencer: feeds X, block and H to the external multiplier stage and
// folds each product back into X, X_i = (X_{i-1} ^ B_i) * H.
// Build option: GHASH_LEN_BLOCK_EN appends {aad_bits,ct_bits} after blk_last.
//
// state  | meaning
// IDLE   | waiting for start; s_out holds the last result
// ACCEPT | blk_ready high; a handshake issues X/block/H to the multiplier
// WAIT   | multiplier latency; product appears in the following state
// LEN    | issue the length block (GHASH_LEN_BLOCK_EN builds only)
// DONE   | last product captured into s_out; done pulses next cycle
//
// The multiplier registers our registered operands one edge after issue, so
// its product is only readable in the cycle after WAIT ends. Rather than
// spending a further WAIT cycle to register it, the successor state reads
// mul_o directly (x_cur) and writes it into X. The operands stay put while the
// successor state lasts, so mul_o keeps the same value for its whole span.
module ghash_sequencer
  import gcm_pkg::*;
#(
  parameter int MUL_LAT = 1,
  parameter int LEN_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  block_t           h_in,
  input  logic [0:LEN_W-1] aad_bits,
  input  logic [0:LEN_W-1] ct_bits,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  block_t           blk_data,
  input  logic             blk_last,
  output block_t           mul_a,
  output block_t           mul_b,
  output block_t           mul_h,
  input  block_t           mul_o,
  output logic             busy,
  output logic             done,
  output block_t           s_out
);

  localparam int CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

  ghash_state_t     state_q, state_d;
  block_t           x_q, x_d;
  block_t           h_q, h_d;
  block_t           mul_a_q, mul_a_d;
  block_t           mul_b_q, mul_b_d;
  block_t           mul_h_q, mul_h_d;
  block_t           s_out_q, s_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  block_t           x_cur;

`ifdef GHASH_LEN_BLOCK_EN
  logic [0:LEN_W-1]   aad_q, aad_d;
  logic [0:LEN_W-1]   ct_q, ct_d;
  logic               len_q, len_d;
  logic [0:2*LEN_W-1] len_cat;

  assign len_cat = {aad_q, ct_q};
`else
  // Length fields are the caller's job in this build; the ports stay for
  // pin compatibility only.
  logic unused_len;
  assign unused_len = ^{aad_bits, ct_bits};
`endif

  // Running hash as seen this cycle: a product left pending by WAIT wins.
  assign x_cur = pend_q ? mul_o : x_q;

  // Next-state, operand issue and hash update.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    h_d     = h_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    mul_h_d = mul_h_q;
    s_out_d = s_out_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef GHASH_LEN_BLOCK_EN
    aad_d   = aad_q;
    ct_d    = ct_q;
    len_d   = len_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCEPT;
          x_d     = ZERO_BLK;
          h_d     = h_in;
          last_d  = 1'b0;
          pend_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef GHASH_LEN_BLOCK_EN
          aad_d   = aad_bits;
          ct_d    = ct_bits;
          len_d   = 1'b0;
`endif
        end
      end
      ACCEPT: begin
        x_d    = x_cur;
        pend_d = 1'b0;
        if (blk_valid) begin
          mul_a_d = x_cur;
          mul_b_d = blk_data;
          mul_h_d = h_q;
          last_d  = blk_last;
          cnt_d   = CNT_W'(MUL_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          pend_d = 1'b1;
`ifdef GHASH_LEN_BLOCK_EN
          if (len_q)       state_d = DONE;
          else if (last_q) state_d = LEN;
          else             state_d = ACCEPT;
`else
          if (last_q) state_d = DONE;
          else        state_d = ACCEPT;
`endif
        end
      end
`ifdef GHASH_LEN_BLOCK_EN
      LEN: begin
        x_d     = x_cur;
        pend_d  = 1'b0;
        mul_a_d = x_cur;
        mul_b_d = block_t'(len_cat);
        mul_h_d = h_q;
        len_d   = 1'b1;
        cnt_d   = CNT_W'(MUL_LAT);
        state_d = WAIT;
      end
`endif
      DONE: begin
        x_d     = x_cur;
        pend_d  = 1'b0;
        s_out_d = x_cur;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= ZERO_BLK;
      h_q     <= ZERO_BLK;
      mul_a_q <= ZERO_BLK;
      mul_b_q <= ZERO_BLK;
      mul_h_q <= ZERO_BLK;
      s_out_q <= ZERO_BLK;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef GHASH_LEN_BLOCK_EN
      aad_q   <= '0;
      ct_q    <= '0;
      len_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      h_q     <= h_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      mul_h_q <= mul_h_d;
      s_out_q <= s_out_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef GHASH_LEN_BLOCK_EN
      aad_q   <= aad_d;
      ct_q    <= ct_d;
      len_q   <= len_d;
`endif
    end
  end

  assign blk_ready = (state_q == ACCEPT);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_h     = mul_h_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign s_out     = s_out_q;

endmodule

// File: doc/ghash_sequencer.md
Name: ghash_sequencer

Overview:
- Control stage directly upstream of the GHASH multiply stage. That stage registers (i1^i2) and i3, then outputs the GF(2^128) product combinationally on the following cycle.
- This block accepts a stream of 128-bit AAD/ciphertext blocks and drives the multiplier with X (running hash), the block, and H.
- It captures the product back into X and emits the final GHASH value S for the tag unit.
- Strict iteration: X_i = (X_{i-1} ^ B_i) * H, with X_0 = 0.

Parameters:
- MUL_LAT, 1, cycles from issuing operands (multiplier input-register edge) to product valid on mul_o.
- LEN_W, 64, width of each bit-length field in the length block.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; clears X, latches h_in, aad_bits, ct_bits; accepted only in IDLE.
- h_in  in  [0:127]  hash subkey H = E_K(0^128).
- aad_bits  in  [0:LEN_W-1]  AAD length in bits.
- ct_bits  in  [0:LEN_W-1]  ciphertext length in bits.
- blk_valid  in  1  input block valid.
- blk_ready  out  1  sequencer can accept a block.
- blk_data  in  [0:127]  block, bit 0 = MSB of byte 0; caller zero-pads partial blocks.
- blk_last  in  1  final data block of the message.
- mul_a  out  [0:127]  to multiplier i1 (X).
- mul_b  out  [0:127]  to multiplier i2 (block).
- mul_h  out  [0:127]  to multiplier i3 (H).
- mul_o  in  [0:127]  multiplier product.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse; S valid.
- s_out  out  [0:127]  final GHASH value; held until next start.

Behaviour:
- Reset values: blk_ready=0, busy=0, done=0, s_out=0, mul_a/mul_b/mul_h=0. Internal X=0, H=0, state=IDLE.
- FSM states: IDLE, ACCEPT, WAIT, LEN, DONE.
- IDLE:
  - start -> ACCEPT, X<=0, H<=h_in, lengths latched, busy<=1.
  - start outside IDLE is ignored.
- ACCEPT:
  - blk_ready=1.
  - On blk_valid&&blk_ready: mul_a<=X, mul_b<=blk_data, mul_h<=H; last flag latched; counter<=MUL_LAT -> WAIT.
  - Operands are registered so they are stable for the multiplier's input register on the next edge.
- WAIT:
  - blk_ready=0; counter decrements.
  - When counter hits 0 (product valid): X<=mul_o.
  - If last flag clear -> ACCEPT.
  - If last flag set -> LEN (with macro) or DONE (without).
- LEN:
  - Issue mul_a=X, mul_b={aad_bits,ct_bits}, mul_h=H.
  - Go to WAIT with last-length flag; its result leads to DONE.
- DONE: s_out<=X, done=1 for one cycle, busy<=0 -> IDLE.
- Throughput: one block per MUL_LAT+1 cycles. Default: block accepted at cycle N, next block accepted at N+2.
- Zero-length message: caller asserts blk_last on an all-zero block; there is no empty-message shortcut.
- blk_valid held while blk_ready=0: data not consumed; caller must hold it stable.
- Mid-operation rst: everything returns to reset values the next edge; no done pulse; s_out=0.
- Operand outputs hold their last values between issues; the multiplier recomputes harmlessly.

Optional Feature:
- Macro GHASH_LEN_BLOCK_EN.
- Defined: after blk_last, the block appends the length block {aad_bits,ct_bits} automatically.
- Undefined: LEN state absent; aad_bits/ct_bits ports remain but are unused. The caller must send the length block as its own final blk_last block.

Decomposition:
- Shared package gcm_pkg: typedef block_t = logic [0:127]; typedef ghash_state_t enum {IDLE, ACCEPT, WAIT, LEN, DONE}; localparam BLK_W=128; localparam ZERO_BLK.
- Package also holds the existing fn_product reference for verification.
- No sub-module inside. The multiplier stage is instantiated beside this block at the top level, not within it.

Test Plan:
- Reset then idle: rst high 3 cycles -> blk_ready=0, busy=0, s_out=0, done=0; start after release -> busy=1 next cycle.
- GCM test case 2 (macro on): H=66e94bd4ef8a2c3b884cfa59ca342b2e, one block C=0388dace60b6a392f328c2b971b2fe78 with last, aad_bits=0, ct_bits=128 -> s_out=f38cbb1ad69223dcc3457ae5b6b0f885, done pulses once.
- Same vector, macro off: send C then 00000000000000000000000000000080 as last -> identical s_out.
- Backpressure: blk_valid held continuously over 4 blocks -> blk_ready high only in ACCEPT cycles (every 2nd cycle); each block consumed exactly once; s_out matches model.
- H=0, arbitrary blocks -> s_out=0.
- rst asserted during WAIT of block 2 of 3 -> no done pulse, s_out=0. A fresh start with test case 2 then yields the correct result.
